// File: rtl/exu_lsu_pkg.sv
// Load/store unit shared definitions.
// FSM encodings, access sizes and funct3 load codes.
package exu_lsu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Natural alignment check; only funct3[1:0] carries the size.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] a);
        logic m;
        case (f3[1:0])
            SZ_B:    m = 1'b0;
            SZ_H:    m = a[0];
            SZ_W:    m = |a;
            default: m = |a;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/exu_lsu_align.sv
// Load/store lane steering.
// Store byte enables and replication, load extraction and extension.
module exu_lsu_align
    import exu_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: enables follow the byte offset, data replicated per lane.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            SZ_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load side: pick the addressed byte/half and extend it.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   ldata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  ldata_o = {24'd0, byte_sel};
            F3_LH:   ldata_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  ldata_o = {16'd0, half_sel};
            F3_LW:   ldata_o = rdata_i;
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/exu_lsu.sv
// Execute-stage load/store unit.
// One outstanding access: IDLE -> REQ (until grant) -> WAIT (until response).
module exu_lsu
    import exu_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd_idx,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic        i_bus_err,
    input  logic [31:0] i_bus_rdata,
    output logic        o_lsu_stall,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_misalign_exc,
    output logic        o_bus_exc
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        we_q;
    logic        mis_q, mis_d;
    logic        bexc_q, bexc_d;
    logic        wbv_q, wbv_d;
    logic [4:0]  wbrd_q;
    logic [31:0] wbdata_q;

    logic        req, mis, capture, done;
    logic [3:0]  be;
    logic [31:0] wd, ld;

    exu_lsu_align u_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (i_bus_rdata),
        .be_o      (be),
        .wdata_o   (wd),
        .ldata_o   (ld)
    );

    assign req = i_mem_ren | i_mem_wen;
    assign mis = misaligned(i_funct3, i_mem_addr[1:0]);

    // Next state, timeout counter and one-cycle pulse requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        done    = 1'b0;
        mis_d   = 1'b0;
        bexc_d  = 1'b0;
        wbv_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && mis) begin
                    mis_d = 1'b1;
                end else if (req) begin
                    capture = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_bus_gnt) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            ST_WAIT: begin
                if (i_bus_rvalid) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    bexc_d  = i_bus_err;
                    wbv_d   = !i_bus_err && !we_q;
                end else if (cnt_q == TO_LAST) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    bexc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured request and registered result/exception outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            f3_q     <= 3'd0;
            rd_q     <= 5'd0;
            we_q     <= 1'b0;
            mis_q    <= 1'b0;
            bexc_q   <= 1'b0;
            wbv_q    <= 1'b0;
            wbrd_q   <= 5'd0;
            wbdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            bexc_q  <= bexc_d;
            wbv_q   <= wbv_d;
            if (capture) begin
                addr_q  <= i_mem_addr;
                wdata_q <= i_mem_wdata;
                f3_q    <= i_funct3;
                rd_q    <= i_rd_idx;
                we_q    <= i_mem_wen;
            end
            if (wbv_d) begin
                wbrd_q   <= rd_q;
                wbdata_q <= ld;
            end
        end
    end

    // Bus drive is gated by REQ so the bus reads zero outside a request.
    always_comb begin
        o_bus_req   = (state_q == ST_REQ);
        o_bus_we    = o_bus_req & we_q;
        o_bus_addr  = o_bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
        o_bus_be    = o_bus_req ? be : 4'd0;
        o_bus_wdata = o_bus_req ? wd : 32'd0;
        o_lsu_stall = ((state_q != ST_IDLE) && !done)
                    || ((state_q == ST_IDLE) && req && !mis);
    end

    assign o_wb_valid     = wbv_q;
    assign o_wb_rd        = wbrd_q;
    assign o_wb_data      = wbdata_q;
    assign o_misalign_exc = mis_q;
    assign o_bus_exc      = bexc_q;

endmodule

// File: tb/tb_exu_lsu.sv
// Directed bench for exu_lsu.
// Vector table for single transactions plus multi-cycle corner sequences.
module tb_exu_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ren, wen, gnt, rvalid, err;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        bus_req, bus_we, stall, wb_valid, mis_exc, bus_exc;
    logic [31:0] bus_addr, bus_wdata, wb_data;
    logic [3:0]  bus_be;
    logic [4:0]  wb_rd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exu_lsu #(.TIMEOUT(16)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_mem_ren      (ren),
        .i_mem_wen      (wen),
        .i_mem_addr     (addr),
        .i_mem_wdata    (wdata),
        .i_funct3       (f3),
        .i_rd_idx       (rd),
        .o_bus_req      (bus_req),
        .o_bus_we       (bus_we),
        .o_bus_addr     (bus_addr),
        .o_bus_wdata    (bus_wdata),
        .o_bus_be       (bus_be),
        .i_bus_gnt      (gnt),
        .i_bus_rvalid   (rvalid),
        .i_bus_err      (err),
        .i_bus_rdata    (rdata),
        .o_lsu_stall    (stall),
        .o_wb_valid     (wb_valid),
        .o_wb_rd        (wb_rd),
        .o_wb_data      (wb_data),
        .o_misalign_exc (mis_exc),
        .o_bus_exc      (bus_exc)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] e_baddr;
        logic [3:0]  e_be;
        logic [31:0] e_bwdata;
        logic        e_wb;
        logic [31:0] e_wdat;
        logic        e_exc;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        string t;
        t = $sformatf("v%0d", i);
        step;
        ren = v.ren; wen = v.wen; addr = v.addr;
        wdata = v.wdata; f3 = v.f3; rd = v.rd;
        #1;
        chk({t, "_stall_req"}, 32'(stall), 32'd1);
        chk({t, "_noreq_idle"}, 32'(bus_req), 32'd0);
        step;
        ren = 1'b0; wen = 1'b0;
        chk({t, "_bus_req"}, 32'(bus_req), 32'd1);
        chk({t, "_bus_we"}, 32'(bus_we), 32'(v.wen));
        chk({t, "_bus_addr"}, bus_addr, v.e_baddr);
        if (v.wen) begin
            chk({t, "_bus_be"}, 32'(bus_be), 32'(v.e_be));
            chk({t, "_bus_wdata"}, bus_wdata, v.e_bwdata);
        end
        gnt = 1'b1;
        step;
        gnt = 1'b0;
        chk({t, "_req_low_wait"}, 32'(bus_req), 32'd0);
        chk({t, "_stall_wait"}, 32'(stall), 32'd1);
        rvalid = 1'b1; rdata = v.rdata; err = v.err;
        #1;
        chk({t, "_stall_done"}, 32'(stall), 32'd0);
        step;
        rvalid = 1'b0; err = 1'b0;
        chk({t, "_wb_valid"}, 32'(wb_valid), 32'(v.e_wb));
        if (v.e_wb) begin
            chk({t, "_wb_data"}, wb_data, v.e_wdat);
            chk({t, "_wb_rd"}, 32'(wb_rd), 32'(v.rd));
        end
        chk({t, "_bus_exc"}, 32'(bus_exc), 32'(v.e_exc));
        step;
        chk({t, "_wb_pulse"}, 32'(wb_valid), 32'd0);
        chk({t, "_exc_pulse"}, 32'(bus_exc), 32'd0);
    endtask

    initial begin
        int k;
        tbl[0]  = '{1'b1, 1'b0, 32'h1000, 32'h0, 3'b010, 5'd5, 32'hDEADBEEF,
                    1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h1003, 32'h0, 3'b000, 5'd6, 32'h80FFFFFF,
                    1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h1003, 32'h0, 3'b100, 5'd7, 32'h80FFFFFF,
                    1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'h00000080, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h1002, 32'h0, 3'b001, 5'd8, 32'h80011234,
                    1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'hFFFF8001, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h1000, 32'h0, 3'b101, 5'd9, 32'h1234F00D,
                    1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'h0000F00D, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h1001, 32'h0, 3'b000, 5'd10, 32'h11227F33,
                    1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'h0000007F, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h2002, 32'h1234, 3'b001, 5'd0, 32'h0,
                    1'b0, 32'h2000, 4'b1100, 32'h12341234, 1'b0, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h3001, 32'hFFFFFFA5, 3'b000, 5'd0, 32'h0,
                    1'b0, 32'h3000, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'h4000, 32'hCAFEF00D, 3'b010, 5'd0, 32'h0,
                    1'b0, 32'h4000, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h4004, 32'h0, 3'b010, 5'd11, 32'h55555555,
                    1'b1, 32'h4004, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 32'h5000, 32'h87654321, 3'b010, 5'd12,
                    32'h99999999, 1'b0, 32'h5000, 4'b1111, 32'h87654321,
                    1'b0, 32'h0, 1'b0};

        rst_n = 1'b0; ren = 1'b0; wen = 1'b0; gnt = 1'b0;
        rvalid = 1'b0; err = 1'b0; addr = '0; wdata = '0;
        rdata = '0; f3 = '0; rd = '0;
        step;
        step;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_exc", 32'({mis_exc, bus_exc}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

        // misaligned word load
        step;
        ren = 1'b1; f3 = 3'b010; addr = 32'h1001;
        #1;
        chk("mis_stall", 32'(stall), 32'd0);
        step;
        ren = 1'b0;
        chk("mis_exc", 32'(mis_exc), 32'd1);
        chk("mis_noreq", 32'(bus_req), 32'd0);
        step;
        chk("mis_exc_pulse", 32'(mis_exc), 32'd0);
        chk("mis_noreq2", 32'(bus_req), 32'd0);
        // misaligned half load
        ren = 1'b1; f3 = 3'b001; addr = 32'h1003;
        step;
        ren = 1'b0;
        chk("mish_exc", 32'(mis_exc), 32'd1);
        chk("mish_noreq", 32'(bus_req), 32'd0);

        // grant withheld, then no response until timeout
        step;
        ren = 1'b1; f3 = 3'b010; addr = 32'h6000; rd = 5'd4;
        step;
        ren = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("to_req_held", 32'(bus_req), 32'd1);
            chk("to_addr_stable", bus_addr, 32'h6000);
            step;
        end
        gnt = 1'b1;
        step;
        gnt = 1'b0;
        chk("to_wait_noreq", 32'(bus_req), 32'd0);
        k = 0;
        while (!bus_exc && k < 40) begin
            k++;
            step;
        end
        chk("to_wait_cycles", 32'(k), 32'd16);
        chk("to_no_wb", 32'(wb_valid), 32'd0);
        chk("to_stall_idle", 32'(stall), 32'd0);
        step;
        chk("to_exc_pulse", 32'(bus_exc), 32'd0);
        run_vec(tbl[0], 20);

        // reset asserted during REQ
        step;
        ren = 1'b1; f3 = 3'b010; addr = 32'h7000; rd = 5'd9;
        step;
        ren = 1'b0;
        chk("rq_req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rq_req0", 32'(bus_req), 32'd0);
        chk("rq_addr0", bus_addr, 32'd0);
        chk("rq_be0", 32'(bus_be), 32'd0);
        chk("rq_stall0", 32'(stall), 32'd0);
        chk("rq_wbdata0", wb_data, 32'd0);
        step;
        rst_n = 1'b1;
        ren = 1'b1; f3 = 3'b010; addr = 32'h7004; rd = 5'd3;
        #1;
        chk("rel_stall", 32'(stall), 32'd1);
        step;
        ren = 1'b0;
        chk("rel_first_req", 32'(bus_req), 32'd1);
        gnt = 1'b1;
        step;
        gnt = 1'b0;
        chk("rw_stall", 32'(stall), 32'd1);
        // reset asserted during WAIT
        #2 rst_n = 1'b0;
        #1;
        chk("rw_stall0", 32'(stall), 32'd0);
        chk("rw_req0", 32'(bus_req), 32'd0);
        chk("rw_exc0", 32'({mis_exc, bus_exc}), 32'd0);
        step;
        rst_n = 1'b1;
        rvalid = 1'b1; rdata = 32'h12345678;
        step;
        rvalid = 1'b0;
        chk("rw_late_wb", 32'(wb_valid), 32'd0);
        chk("rw_late_exc", 32'(bus_exc), 32'd0);
        chk("rw_late_stall", 32'(stall), 32'd0);
        chk("rw_late_data", wb_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
